// File: rtl/bus_fabric_if.sv
// CPU-side native memory bus plus per-slave select/ready/rdata.
// "slave" modport is the fabric's view; "master" is the environment (CPU + slaves).
interface bus_fabric_if #(
  parameter int NSLAVES = 6
);
  logic                    mem_valid;
  logic [31:0]             mem_addr;
  logic [3:0]              mem_wstrb;
  logic                    mem_ready;
  logic [31:0]             mem_rdata;
  logic [NSLAVES-1:0]      slv_sel;
  logic [NSLAVES-1:0]      slv_ready;
  logic [32*NSLAVES-1:0]   slv_rdata;
  logic                    err_irq;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
    input  mem_ready, mem_rdata, slv_sel, err_irq
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
    output mem_ready, mem_rdata, slv_sel, err_irq
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-master decode/mux with status target and per-access watchdog.
// Slave hits complete with zero added latency; unmapped/status/abort answer one cycle after the trigger.
module bus_fabric #(
  parameter int                    NSLAVES   = 6,
  parameter logic [32*NSLAVES-1:0] SLV_BASE  = '0,
  parameter logic [32*NSLAVES-1:0] SLV_MASK  = '0,
  parameter int                    TIMEOUT   = 255,
  parameter logic [31:0]           ERR_RDATA = 32'hdeadbeef,
  parameter logic [31:0]           STAT_ADDR = 32'h8000_0020
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_fabric_if.slave   bus
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0] ERR_ADDR_REG = STAT_ADDR + 32'd4;

  logic               int_ready;
  logic [31:0]        int_rdata;
  logic               abort;
  logic [WW-1:0]      wcnt;
  logic [31:0]        err_count;
  logic [31:0]        err_addr;
  logic               err_irq_q;

  logic               cnt_hit;
  logic               stat_hit;
  logic [NSLAVES-1:0] winner;
  logic               any_win;
  logic [NSLAVES-1:0] sel;
  logic               slv_done;
  logic               stat_ev;
  logic               unmapped_ev;
  logic               wd_ev;
  logic               rec_err;

  assign cnt_hit  = (bus.mem_addr == STAT_ADDR);
  assign stat_hit = cnt_hit | (bus.mem_addr == ERR_ADDR_REG);

  // Lowest-index window wins; the status target masks every window.
  always_comb begin
    winner  = '0;
    any_win = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!any_win && ((bus.mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        winner[i] = 1'b1;
        any_win   = 1'b1;
      end
    end
    if (stat_hit) begin
      winner  = '0;
      any_win = 1'b0;
    end
  end

  assign sel      = (bus.mem_valid && reset_n && !abort) ? winner : '0;
  assign slv_done = |(bus.slv_ready & sel);

  assign bus.slv_sel   = sel;
  assign bus.mem_ready = bus.mem_valid & (slv_done | int_ready);
  assign bus.err_irq   = err_irq_q;

  always_comb begin
    bus.mem_rdata = ERR_RDATA;
    if (int_ready) begin
      bus.mem_rdata = int_rdata;
    end else begin
      for (int i = 0; i < NSLAVES; i++) begin
        if (sel[i]) bus.mem_rdata = bus.slv_rdata[32*i +: 32];
      end
    end
  end

  assign stat_ev     = bus.mem_valid & ~int_ready & stat_hit;
  assign unmapped_ev = bus.mem_valid & ~int_ready & ~stat_hit & ~any_win;
  assign wd_ev       = (TIMEOUT != 0) & bus.mem_valid & ~int_ready & any_win & ~abort
                       & ~slv_done & (wcnt == WLAST);
  assign rec_err     = unmapped_ev | wd_ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_ready <= 1'b0;
      int_rdata <= ERR_RDATA;
      abort     <= 1'b0;
      wcnt      <= '0;
      err_count <= '0;
      err_addr  <= '0;
      err_irq_q <= 1'b0;
    end else begin
      int_ready <= stat_ev | rec_err;
      err_irq_q <= rec_err;

      if (rec_err) begin
        err_count <= (err_count == 32'hFFFF_FFFF) ? err_count : err_count + 32'd1;
        err_addr  <= bus.mem_addr;
        int_rdata <= ERR_RDATA;
      end else if (stat_ev) begin
        int_rdata <= cnt_hit ? err_count : err_addr;
        if (cnt_hit && (|bus.mem_wstrb)) err_count <= '0;
      end

      if (!bus.mem_valid || bus.mem_ready || wd_ev) begin
        wcnt <= '0;
      end else if (any_win && !abort && (TIMEOUT != 0)) begin
        wcnt <= wcnt + WW'(1);
      end

      // Abort holds the select low until the CPU retires the request.
      if (!bus.mem_valid) begin
        abort <= 1'b0;
      end else if (wd_ev) begin
        abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: decode, overlap priority, unmapped, watchdog, status, reset.
module tb_bus_fabric;
  localparam logic [95:0] BASE    = {32'h8000_0000, 32'h0002_0000, 32'h0000_0000};
  localparam logic [95:0] MASK    = {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFE_0000};
  localparam logic [95:0] BASE_OV = {32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [95:0] MASK_OV = {32'hFFFF_FFF0, 32'hFFFE_0000, 32'hFFFE_0000};
  localparam logic [31:0] STAT    = 32'h8000_0020;
  localparam logic [31:0] EADDR   = 32'h8000_0024;
  localparam logic [31:0] BAD     = 32'hdeadbeef;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_fabric_if #(.NSLAVES(3)) bi();
  bus_fabric_if #(.NSLAVES(3)) bo();

  bus_fabric #(.NSLAVES(3), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8),
               .ERR_RDATA(BAD), .STAT_ADDR(STAT))
    dut (.clk(clk), .reset_n(reset_n), .bus(bi.slave));

  bus_fabric #(.NSLAVES(3), .SLV_BASE(BASE_OV), .SLV_MASK(MASK_OV), .TIMEOUT(8),
               .ERR_RDATA(BAD), .STAT_ADDR(STAT))
    dut_ov (.clk(clk), .reset_n(reset_n), .bus(bo.slave));

  task step();
    @(posedge clk);
    #1;
  endtask

  task smp();
    @(negedge clk);
  endtask

  task drive(input logic v, input logic [31:0] a, input logic [3:0] w, input logic [2:0] rdy);
    bi.mem_valid = v;
    bi.mem_addr  = a;
    bi.mem_wstrb = w;
    bi.slv_ready = rdy;
  endtask

  // Two-cycle internal-target access; returns ready in cycles 0/1 and the cycle-1 data.
  task automatic stat_acc(input logic [31:0] a, input logic [3:0] w,
                          output logic r0, output logic r1, output logic [31:0] d);
    step();
    drive(1'b1, a, w, 3'b000);
    smp();
    r0 = bi.mem_ready;
    step();
    smp();
    r1 = bi.mem_ready;
    d  = bi.mem_rdata;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
  endtask

  task test_reset();
    smp();
    checks++; if (bi.mem_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== BAD) $display("FAIL rst_rdata got %h want %h", bi.mem_rdata, BAD); else passed++;
    checks++; if (bi.slv_sel !== 3'b000) $display("FAIL rst_sel got %b want 000", bi.slv_sel); else passed++;
    checks++; if (bi.err_irq !== 1'b0) $display("FAIL rst_irq got %b want 0", bi.err_irq); else passed++;
    checks++; if (dut.err_count !== 32'h0) $display("FAIL rst_count got %h want 0", dut.err_count); else passed++;
    checks++; if (dut.err_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", dut.err_addr); else passed++;
    step();
    reset_n = 1'b1;
  endtask

  task test_decode();
    step();
    drive(1'b1, 32'h8000_0004, 4'h0, 3'b011);
    smp();
    checks++; if (bi.slv_sel !== 3'b100) $display("FAIL dec_sel got %b want 100", bi.slv_sel); else passed++;
    checks++; if (bi.mem_ready !== 1'b0) $display("FAIL dec_unsel_rdy got %b want 0", bi.mem_ready); else passed++;
    step();
    bi.slv_ready = 3'b000;
    smp();
    checks++; if (bi.mem_ready !== 1'b0) $display("FAIL dec_c1_rdy got %b want 0", bi.mem_ready); else passed++;
    step();
    bi.slv_ready = 3'b100;
    smp();
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL dec_c2_rdy got %b want 1", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== 32'hCCCC_0002) $display("FAIL dec_c2_rdata got %h want CCCC0002", bi.mem_rdata); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    step();
    drive(1'b1, 32'h0002_0010, 4'h0, 3'b010);
    smp();
    checks++; if (bi.slv_sel !== 3'b010) $display("FAIL dec1_sel got %b want 010", bi.slv_sel); else passed++;
    checks++; if (bi.mem_rdata !== 32'hBBBB_0001) $display("FAIL dec1_rdata got %h want BBBB0001", bi.mem_rdata); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    step();
    drive(1'b1, 32'h0001_FFFC, 4'hF, 3'b001);
    smp();
    checks++; if (bi.slv_sel !== 3'b001) $display("FAIL dec0_sel got %b want 001", bi.slv_sel); else passed++;
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL dec0_rdy got %b want 1", bi.mem_ready); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
  endtask

  task test_overlap();
    step();
    bo.mem_valid = 1'b1;
    bo.mem_addr  = 32'h0000_1000;
    bo.slv_ready = 3'b011;
    smp();
    checks++; if (bo.slv_sel !== 3'b001) $display("FAIL ovl_sel got %b want 001", bo.slv_sel); else passed++;
    checks++; if (bo.mem_rdata !== 32'hAAAA_0000) $display("FAIL ovl_rdata got %h want AAAA0000", bo.mem_rdata); else passed++;
    step();
    bo.mem_valid = 1'b0;
    bo.slv_ready = 3'b000;
  endtask

  task test_unmapped();
    logic r0, r1;
    logic [31:0] d;
    step();
    drive(1'b1, 32'h4000_0000, 4'h0, 3'b000);
    smp();
    checks++; if (bi.mem_ready !== 1'b0) $display("FAIL unm_c0_rdy got %b want 0", bi.mem_ready); else passed++;
    checks++; if (bi.slv_sel !== 3'b000) $display("FAIL unm_sel got %b want 000", bi.slv_sel); else passed++;
    step();
    smp();
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL unm_c1_rdy got %b want 1", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== BAD) $display("FAIL unm_rdata got %h want %h", bi.mem_rdata, BAD); else passed++;
    checks++; if (bi.err_irq !== 1'b1) $display("FAIL unm_irq got %b want 1", bi.err_irq); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    smp();
    checks++; if (bi.err_irq !== 1'b0) $display("FAIL unm_irq_pulse got %b want 0", bi.err_irq); else passed++;
    stat_acc(STAT, 4'h0, r0, r1, d);
    checks++; if ({r0, r1} !== 2'b01) $display("FAIL stat_rd_timing got %b want 01", {r0, r1}); else passed++;
    checks++; if (d !== 32'd1) $display("FAIL unm_count got %h want 1", d); else passed++;
    stat_acc(EADDR, 4'h0, r0, r1, d);
    checks++; if (d !== 32'h4000_0000) $display("FAIL unm_addr got %h want 40000000", d); else passed++;
  endtask

  task test_hung();
    logic r0, r1;
    logic [31:0] d;
    step();
    drive(1'b1, 32'h8000_0004, 4'h0, 3'b000);
    for (int k = 0; k < 8; k++) begin
      smp();
      checks++; if (bi.slv_sel !== 3'b100) $display("FAIL hung_sel_c%0d got %b want 100", k, bi.slv_sel); else passed++;
      checks++; if (bi.mem_ready !== 1'b0) $display("FAIL hung_rdy_c%0d got %b want 0", k, bi.mem_ready); else passed++;
      step();
    end
    bi.slv_ready = 3'b100;
    smp();
    checks++; if (bi.slv_sel !== 3'b000) $display("FAIL hung_sel_c8 got %b want 000", bi.slv_sel); else passed++;
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL hung_rdy_c8 got %b want 1", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== BAD) $display("FAIL hung_rdata got %h want %h", bi.mem_rdata, BAD); else passed++;
    checks++; if (bi.err_irq !== 1'b1) $display("FAIL hung_irq got %b want 1", bi.err_irq); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    stat_acc(STAT, 4'h0, r0, r1, d);
    checks++; if (d !== 32'd2) $display("FAIL hung_count got %h want 2", d); else passed++;

    step();
    drive(1'b1, 32'h8000_0004, 4'h0, 3'b000);
    for (int k = 0; k < 7; k++) begin
      smp();
      checks++; if (bi.mem_ready !== 1'b0) $display("FAIL late_rdy_c%0d got %b want 0", k, bi.mem_ready); else passed++;
      step();
    end
    bi.slv_ready = 3'b100;
    smp();
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL late_rdy_c7 got %b want 1", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== 32'hCCCC_0002) $display("FAIL late_rdata got %h want CCCC0002", bi.mem_rdata); else passed++;
    checks++; if (bi.err_irq !== 1'b0) $display("FAIL late_irq_c7 got %b want 0", bi.err_irq); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    smp();
    checks++; if (bi.err_irq !== 1'b0) $display("FAIL late_irq_c8 got %b want 0", bi.err_irq); else passed++;
    stat_acc(STAT, 4'h0, r0, r1, d);
    checks++; if (d !== 32'd2) $display("FAIL late_count got %h want 2", d); else passed++;
  endtask

  task test_status();
    logic r0, r1;
    logic [31:0] d;
    stat_acc(STAT, 4'hF, r0, r1, d);
    checks++; if ({r0, r1} !== 2'b01) $display("FAIL stat_wr_timing got %b want 01", {r0, r1}); else passed++;
    stat_acc(STAT, 4'h0, r0, r1, d);
    checks++; if (d !== 32'd0) $display("FAIL stat_clear got %h want 0", d); else passed++;
    stat_acc(EADDR, 4'hF, r0, r1, d);
    stat_acc(EADDR, 4'h0, r0, r1, d);
    checks++; if (d !== 32'h8000_0004) $display("FAIL stat_addr_keep got %h want 80000004", d); else passed++;
  endtask

  task test_reset_mid();
    step();
    drive(1'b1, 32'h4000_0008, 4'h0, 3'b000);
    step();
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    smp();
    checks++; if (dut.err_count !== 32'd1) $display("FAIL pre_rst_count got %h want 1", dut.err_count); else passed++;
    step();
    drive(1'b1, 32'h8000_0000, 4'h0, 3'b000);
    step();
    step();
    step();
    reset_n = 1'b0;
    smp();
    checks++; if (bi.slv_sel !== 3'b000) $display("FAIL mrst_sel got %b want 000", bi.slv_sel); else passed++;
    checks++; if (bi.mem_ready !== 1'b0) $display("FAIL mrst_rdy got %b want 0", bi.mem_ready); else passed++;
    checks++; if (dut.wcnt !== 4'd0) $display("FAIL mrst_wcnt got %0d want 0", dut.wcnt); else passed++;
    checks++; if (dut.err_count !== 32'd0) $display("FAIL mrst_count got %h want 0", dut.err_count); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    step();
    reset_n = 1'b1;
    step();
    drive(1'b1, 32'h0002_0000, 4'h0, 3'b000);
    smp();
    checks++; if (bi.slv_sel !== 3'b010) $display("FAIL post_sel got %b want 010", bi.slv_sel); else passed++;
    step();
    bi.slv_ready = 3'b010;
    smp();
    checks++; if (bi.mem_ready !== 1'b1) $display("FAIL post_rdy got %b want 1", bi.mem_ready); else passed++;
    checks++; if (bi.mem_rdata !== 32'hBBBB_0001) $display("FAIL post_rdata got %h want BBBB0001", bi.mem_rdata); else passed++;
    checks++; if (bi.err_irq !== 1'b0) $display("FAIL post_irq got %b want 0", bi.err_irq); else passed++;
    step();
    drive(1'b0, 32'h0, 4'h0, 3'b000);
  endtask

  initial begin
    drive(1'b0, 32'h0, 4'h0, 3'b000);
    bi.slv_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    bo.mem_valid = 1'b0;
    bo.mem_addr  = 32'h0;
    bo.mem_wstrb = 4'h0;
    bo.slv_ready = 3'b000;
    bo.slv_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    test_reset();
    test_decode();
    test_overlap();
    test_unmapped();
    test_hung();
    test_status();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
